// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite constants and FSM state types for the team's register blocks.
package axi4lite_pkg;
  localparam int unsigned ADDR_LSB = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;
endpackage

// File: rtl/axi4lite_strb_merge.sv
// Byte-strobed word merge: strobed bytes come from wdata_i, the rest keep old_i.
module axi4lite_strb_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic [31:0] new_o
);
  always_comb begin
    new_o = old_i;
    for (int unsigned b = 0; b < 4; b++) begin
      if (wstrb_i[b]) new_o[8*b +: 8] = wdata_i[8*b +: 8];
    end
  end
endmodule

// File: rtl/axi4lite_slave_regfile.sv
// AXI4-Lite responder over NUM_REGS read/write 32-bit registers, with independent
// AW/W capture, byte-strobed commits and per-register write pulses to fabric.
module axi4lite_slave_regfile
  import axi4lite_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                               S_AXI_ACLK,
  input  logic                               S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
  input  logic [2:0]                         S_AXI_AWPROT,
  input  logic                               S_AXI_AWVALID,
  output logic                               S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
  input  logic                               S_AXI_WVALID,
  output logic                               S_AXI_WREADY,
  output logic [1:0]                         S_AXI_BRESP,
  output logic                               S_AXI_BVALID,
  input  logic                               S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
  input  logic [2:0]                         S_AXI_ARPROT,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]                reg_wr_pulse
);
  localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [AW:0] ADDR_LIMIT = (AW+1)'(NUM_REGS * 4);

  function automatic logic [IDX_W-1:0] idx_of(input logic [AW-1:0] a);
    logic [AW-1:0] s;
    s = a >> ADDR_LSB;
    return s[IDX_W-1:0];
  endfunction

  wstate_t wstate_q, wstate_d;
  rstate_t rstate_q, rstate_d;
  logic              rdy_en_q;
  logic              aw_done_q, w_done_q;
  logic [AW-1:0]     awaddr_q;
  logic [DW-1:0]     wdata_q;
  logic [DW/8-1:0]   wstrb_q;
  logic [1:0]        bresp_q, rresp_q;
  logic [DW-1:0]     rdata_q;
  logic [DW-1:0]     regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pulse_q;

  logic aw_hs, w_hs, ar_hs, commit, w_in_range, r_in_range;
  logic [AW-1:0]    waddr_c;
  logic [DW-1:0]    wdata_c, old_c, merged_c;
  logic [DW/8-1:0]  wstrb_c;
  logic [IDX_W-1:0] widx, ridx;
  logic             unused_prot;

  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  // READYs stay low through reset and the first edge after it
  assign S_AXI_AWREADY = rdy_en_q & (wstate_q == W_IDLE) & ~aw_done_q;
  assign S_AXI_WREADY  = rdy_en_q & (wstate_q == W_IDLE) & ~w_done_q;
  assign S_AXI_ARREADY = rdy_en_q & (rstate_q == R_IDLE);
  assign S_AXI_BVALID  = (wstate_q == W_RESP);
  assign S_AXI_RVALID  = (rstate_q == R_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign reg_wr_pulse  = pulse_q;

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  // Whichever channel arrives second is taken straight from the bus
  assign waddr_c = aw_done_q ? awaddr_q : S_AXI_AWADDR;
  assign wdata_c = w_done_q  ? wdata_q  : S_AXI_WDATA;
  assign wstrb_c = w_done_q  ? wstrb_q  : S_AXI_WSTRB;
  assign commit  = (wstate_q == W_IDLE) & (aw_done_q | aw_hs) & (w_done_q | w_hs);

  assign w_in_range = {1'b0, waddr_c} < ADDR_LIMIT;
  assign r_in_range = {1'b0, S_AXI_ARADDR} < ADDR_LIMIT;
  assign widx  = idx_of(waddr_c);
  assign ridx  = idx_of(S_AXI_ARADDR);
  assign old_c = w_in_range ? regs_q[widx] : '0;

  axi4lite_strb_merge u_merge (
    .old_i   (old_c),
    .wdata_i (wdata_c),
    .wstrb_i (wstrb_c),
    .new_o   (merged_c)
  );

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[DW*g +: DW] = regs_q[g];
  end

  always_comb begin
    wstate_d = wstate_q;
    rstate_d = rstate_q;
    unique case (wstate_q)
      W_IDLE: if (commit) wstate_d = W_RESP;
      W_RESP: if (S_AXI_BREADY) wstate_d = W_IDLE;
    endcase
    unique case (rstate_q)
      R_IDLE: if (ar_hs) rstate_d = R_RESP;
      R_RESP: if (S_AXI_RREADY) rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      rdy_en_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      pulse_q   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      rdy_en_q <= 1'b1;
      pulse_q  <= '0;
      if (commit) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        bresp_q   <= w_in_range ? RESP_OKAY : RESP_SLVERR;
        if (w_in_range) begin
          regs_q[widx]  <= merged_c;
          pulse_q[widx] <= 1'b1;
        end
      end else begin
        if (aw_hs) begin
          aw_done_q <= 1'b1;
          awaddr_q  <= S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_done_q <= 1'b1;
          wdata_q  <= S_AXI_WDATA;
          wstrb_q  <= S_AXI_WSTRB;
        end
      end
      if (ar_hs) begin
        rdata_q <= r_in_range ? regs_q[ridx] : '0;
        rresp_q <= r_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end
endmodule

// File: doc/axi4lite_slave_regfile.md
Name: axi4lite_slave_regfile

Overview:
AXI4-Lite responder with a bank of read/write 32-bit control registers, addressed by a bus master (Zynq PS GP port or AXI VIP master).
Captures AW and W independently, commits byte-strobed writes, returns B and R responses with full backpressure support.
Register contents and per-register write strobes go to user fabric logic.
Sits behind the S00_AXI interface of the team's custom IP wrappers.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; must be >= clog2(NUM_REGS)+2.
NUM_REGS, 4, number of registers, 1..16.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
reg_out  out  NUM_REGS*32  flattened register contents; reg i at [32*i +: 32]
reg_wr_pulse  out  NUM_REGS  one-cycle pulse when reg i is committed

Behaviour:
- Reset (ARESETN low, async): all registers 0; AWREADY=WREADY=ARREADY=0; BVALID=RVALID=0; BRESP=RRESP=0; RDATA=0; reg_wr_pulse=0. The first cycle after deassertion asserts the READY outputs.
- Index: idx = addr[2 +: clog2(NUM_REGS)]; addr[1:0] ignored. Out of range when addr >= NUM_REGS*4.
- Write FSM, states W_IDLE, W_RESP:
  - W_IDLE: AWREADY is high until AW is captured; WREADY is high until W is captured. Each channel latches independently, so either order works, including the same cycle.
  - The commit happens on the edge where the second of AW/W is captured. At that edge, bytes with WSTRB[b]=1 update reg[idx]; other bytes are held. reg_wr_pulse[idx]=1 for the following cycle.
  - Out-of-range write: no register changes, no pulse, BRESP=2'b10 (SLVERR). In range: BRESP=2'b00.
  - After commit: BVALID=1 next cycle, state W_RESP, AWREADY=WREADY=0. BVALID holds with BRESP stable until BREADY=1, then return to W_IDLE.
  - Minimum latency: AW and W in the same cycle give BVALID one cycle later. Throughput is one write per 2 cycles when BREADY is tied high.
- Read FSM, states R_IDLE, R_RESP:
  - R_IDLE: ARREADY=1. On handshake, RDATA is registered with reg[idx] as it stands before that edge, or 0 if out of range. RRESP is OKAY or SLVERR. RVALID=1 next cycle.
  - R_RESP: ARREADY=0. RDATA and RRESP hold until RREADY=1, then return to R_IDLE.
- Read and write channels are fully independent. A read and a write commit to the same register on the same edge return the old value.
- reset mid-transaction: outstanding B/R responses are dropped; the master must re-issue.

Decomposition:
- Package axi4lite_pkg: resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10; enum wstate_t {W_IDLE, W_RESP}; enum rstate_t {R_IDLE, R_RESP}; ADDR_LSB=2.
- One sub-module: axi4lite_strb_merge, combinational (old, wdata, wstrb) -> new word, reused by future register blocks.

Test Plan:
- Sequential: write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC with WSTRB=0xF, then read back -> RDATA 0x1..0x4 in order, all BRESP and RRESP = OKAY, reg_wr_pulse seen once per register.
- Strobes: reg0=0x00000001, write 0xAABBCCDD with WSTRB=4'b0101 -> read gives 0x00BB00DD.
- Ordering: W valid 3 cycles before AW to 0x8 with data 0xCAFEF00D -> WREADY drops after W capture, commit on AW capture, BVALID one cycle later, read gives 0xCAFEF00D.
- Backpressure: BREADY and RREADY low for 5 cycles -> BVALID/RVALID, BRESP and RDATA stable throughout; no new AW/AR accepted until the response completes.
- Out of range (instance with C_S_AXI_ADDR_WIDTH=5): write 0xFFFFFFFF to 0x10 -> BRESP=SLVERR, no pulse, registers unchanged; read 0x14 -> RDATA=0, RRESP=SLVERR.
- Reset: assert ARESETN low while BVALID=1 -> BVALID drops immediately (async), reg_out=0; after release, a write to 0x4 with 0x5A completes normally.
